// File: rtl/cam_pattern_tx.sv
// OV7670-style camera emulator: frames of RGB444 test patterns with vsync/href
// timing, all outputs registered one cycle behind the frame FSM.
module cam_pattern_tx #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [11:0] i_solid_rgb,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_pix_byte,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [7:0]  o_frame_cnt
);

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W     = $clog2(LINE_LEN);
  localparam int MAX_LINES = V_ACTIVE + VS_LINES + VBP_LINES + VFP_LINES;
  localparam int LN_W      = $clog2(MAX_LINES + 1);
  localparam int BAR_W     = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [LN_W-1:0]   line, line_nxt;
  logic [1:0]        pat_cap;
  logic [11:0]       solid_cap;
  logic              cap_en;
  logic              frame_end;
  logic              last_col;
  logic              last_line;
  logic              href_nxt;
  logic [15:0]       px;
  logic [15:0]       py;
  logic [11:0]       rgb;
  logic [7:0]        byte_nxt;

  function automatic logic [LN_W-1:0] state_last_line(state_t s);
    case (s)
      S_VSYNC:  return LN_W'(VS_LINES - 1);
      S_VBP:    return LN_W'(VBP_LINES - 1);
      S_ACTIVE: return LN_W'(V_ACTIVE - 1);
      S_VFP:    return LN_W'(VFP_LINES - 1);
      default:  return '0;
    endcase
  endfunction

  // Bar index saturates at 7 so the last bar absorbs any remainder width.
  function automatic logic [11:0] bar_rgb(logic [15:0] x);
    logic [15:0] idx;
    idx = x / 16'(BAR_W);
    if (idx > 16'd7) idx = 16'd7;
    case (idx[2:0])
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] pattern_rgb(logic [1:0] pat, logic [15:0] x,
                                              logic [15:0] y, logic [11:0] solid,
                                              logic [3:0] fcnt);
    case (pat)
      2'd0:    return bar_rgb(x);
      2'd1:    return {x[3:0], y[3:0], fcnt};
      2'd2:    return solid;
      default: return (x[4] ^ y[4]) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  assign last_col  = (col == COL_W'(LINE_LEN - 1));
  assign last_line = (line == state_last_line(state));

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    line_nxt  = line;
    cap_en    = 1'b0;
    frame_end = 1'b0;
    if (state == S_IDLE) begin
      col_nxt  = '0;
      line_nxt = '0;
      if (i_enable) begin
        state_nxt = S_VSYNC;
        cap_en    = 1'b1;
      end
    end else if (!last_col) begin
      col_nxt = col + 1'b1;
    end else begin
      col_nxt = '0;
      if (!last_line) begin
        line_nxt = line + 1'b1;
      end else begin
        line_nxt = '0;
        case (state)
          S_VSYNC:  state_nxt = S_VBP;
          S_VBP:    state_nxt = S_ACTIVE;
          S_ACTIVE: state_nxt = S_VFP;
          default: begin
            frame_end = 1'b1;
            if (i_enable) begin
              state_nxt = S_VSYNC;
              cap_en    = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      col       <= '0;
      line      <= '0;
      pat_cap   <= 2'd0;
      solid_cap <= 12'h000;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      line  <= line_nxt;
      if (cap_en) begin
        pat_cap   <= i_pattern;
        solid_cap <= i_solid_rgb;
      end
    end
  end

  // Pixel generation from the current column/line, consumed by the output register.
  always_comb begin
    href_nxt = (state == S_ACTIVE) && ({1'b0, col} < (COL_W + 1)'(2 * H_ACTIVE));
    px       = 16'(col >> 1);
    py       = 16'(line);
    rgb      = pattern_rgb(pat_cap, px, py, solid_cap, o_frame_cnt[3:0]);
    byte_nxt = 8'h00;
    if (href_nxt) byte_nxt = col[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

  // Output register stage: every output lags the FSM by exactly one cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_vsync      <= 1'b0;
      o_href       <= 1'b0;
      o_pix_byte   <= 8'h00;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= 8'h00;
    end else begin
      o_vsync      <= (state == S_VSYNC);
      o_href       <= href_nxt;
      o_pix_byte   <= byte_nxt;
      o_busy       <= (state != S_IDLE);
      o_frame_done <= frame_end;
      if (frame_end) o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Bench for cam_pattern_tx at small geometry (LINE_LEN=20, 140-cycle frames),
// compared against a frame-position model derived from the timing rules.
module tb_cam_pattern_tx;
  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_enable;
  logic [1:0]  i_pattern;
  logic [11:0] i_solid_rgb;
  logic        o_vsync;
  logic        o_href;
  logic [7:0]  o_pix_byte;
  logic        o_busy;
  logic        o_frame_done;
  logic [7:0]  o_frame_cnt;

  always #5 i_clk = ~i_clk;

  cam_pattern_tx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4),
    .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable),
    .i_pattern(i_pattern), .i_solid_rgb(i_solid_rgb),
    .o_vsync(o_vsync), .o_href(o_href), .o_pix_byte(o_pix_byte),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: position within the 140-cycle frame (7 lines x 20 columns).
  bit          m_run;
  int          m_t;
  logic [1:0]  m_pat;
  logic [11:0] m_solid;
  logic [7:0]  m_fcnt;

  logic [7:0] bar_tab [16] = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
                               8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
  logic [11:0] bar_col [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic logic [11:0] ref_rgb(int x, int y);
    logic [3:0] xb, yb;
    xb = 4'(x);
    yb = 4'(y);
    case (m_pat)
      2'd0:    return bar_col[(x > 7) ? 7 : x];
      2'd1:    return {xb, yb, m_fcnt[3:0]};
      2'd2:    return m_solid;
      default: return ((((x / 16) ^ (y / 16)) % 2) == 1) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_pat = 2'd0; m_solid = 12'h000; m_fcnt = 8'h00;
  endtask

  task automatic step();
    int ln, c;
    logic ev, eh, eb, ed;
    logic [7:0] ep;
    logic [11:0] rgb;
    logic bar_chk;
    ln = m_t / 20;
    c  = m_t % 20;
    ev = m_run && (ln == 0);
    eh = m_run && (ln >= 2) && (ln < 6) && (c < 16);
    eb = m_run;
    ed = m_run && (m_t == 139);
    ep = 8'h00;
    if (eh) begin
      rgb = ref_rgb(c / 2, ln - 2);
      ep  = (c % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
    end
    bar_chk = eh && (m_pat == 2'd0);
    @(posedge i_clk);
    if (!i_rstn) model_reset();
    else if (!m_run) begin
      if (i_enable) begin m_run = 1; m_t = 0; m_pat = i_pattern; m_solid = i_solid_rgb; end
    end else if (m_t == 139) begin
      m_fcnt++;
      if (i_enable) begin m_t = 0; m_pat = i_pattern; m_solid = i_solid_rgb; end
      else m_run = 0;
    end else m_t++;
    #1;
    check("vsync", 8'(o_vsync), 8'(ev));
    check("href", 8'(o_href), 8'(eh));
    check("pix_byte", o_pix_byte, ep);
    check("busy", 8'(o_busy), 8'(eb));
    check("frame_done", 8'(o_frame_done), 8'(ed));
    check("frame_cnt", o_frame_cnt, m_fcnt);
    if (bar_chk) check("bar_table", o_pix_byte, bar_tab[c]);
  endtask

  task automatic run_to(int t);
    int n;
    n = 0;
    while (!(m_run && m_t == t) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $error("FAIL run_to_timeout observed=%0d expected=%0d", m_t, t);
    end
  endtask

  initial begin
    i_rstn = 1'b0; i_enable = 1'b0; i_pattern = 2'd0; i_solid_rgb = 12'h000;
    model_reset();
    #12;
    check("rst_vsync", 8'(o_vsync), 8'h00);
    check("rst_href", 8'(o_href), 8'h00);
    check("rst_pix", o_pix_byte, 8'h00);
    check("rst_busy", 8'(o_busy), 8'h00);
    check("rst_done", 8'(o_frame_done), 8'h00);
    check("rst_cnt", o_frame_cnt, 8'h00);
    step(); step();
    i_rstn = 1'b1;
    step(); step();

    // Solid colour, enable held: three frames of timing plus A5C bytes.
    i_pattern = 2'd2; i_solid_rgb = 12'hA5C; i_enable = 1'b1;
    repeat (3 * 140 + 2) step();
    check("cnt_after_3", o_frame_cnt, 8'd3);

    // Colour bars next frame, then switch to checkerboard mid-ACTIVE.
    i_pattern = 2'd0;
    run_to(139); step();
    run_to(60);
    i_pattern = 2'd3;
    run_to(139); step();
    run_to(139); step();

    // Gradient, then enable dropped in ACTIVE line 2.
    i_pattern = 2'd1;
    run_to(139); step();
    run_to(85);
    i_enable = 1'b0;
    repeat (200) step();
    check("idle_vsync", 8'(o_vsync), 8'h00);
    check("idle_busy", 8'(o_busy), 8'h00);

    // Back-to-back frame when enable returns in the final VFP cycle.
    i_enable = 1'b1; step();
    i_enable = 1'b0;
    run_to(139);
    i_enable = 1'b1;
    step(); step();
    check("b2b_vsync", 8'(o_vsync), 8'h01);
    check("b2b_busy", 8'(o_busy), 8'h01);

    // Asynchronous reset in the middle of href.
    run_to(45);
    #2;
    i_rstn = 1'b0;
    #1;
    check("arst_href", 8'(o_href), 8'h00);
    check("arst_pix", o_pix_byte, 8'h00);
    check("arst_busy", 8'(o_busy), 8'h00);
    check("arst_cnt", o_frame_cnt, 8'h00);
    model_reset();
    step(); step();
    i_rstn = 1'b1;
    repeat (150) step();

    // Randomised pattern/colour/enable activity.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        i_pattern   = 2'($urandom_range(0, 3));
        i_solid_rgb = 12'($urandom);
      end
      if ($urandom_range(0, 119) == 0) i_enable = ~i_enable;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_pattern_tx.md
CAM_PATTERN_TX -- requirements
Module: cam_pattern_tx

Interface
REQ-001 Parameter H_ACTIVE, default 320, SHALL set the active pixels per line.
REQ-002 Parameter V_ACTIVE, default 240, SHALL set the active lines per frame.
REQ-003 Parameter H_BLANK, default 144, SHALL set the byte-clock cycles per line with href low; LINE_LEN = 2*H_ACTIVE + H_BLANK.
REQ-004 Parameters VS_LINES 3, VBP_LINES 17, VFP_LINES 10 SHALL set the vsync, back-porch and front-porch lengths, in lines.
REQ-005 i_clk, input, 1: pixel byte clock; all logic on its rising edge; one clock, no other domain.
REQ-006 i_rstn, input, 1: reset, asynchronous, active-low.
REQ-007 i_enable, input, 1: level; request continuous frame generation.
REQ-008 i_pattern, input, 2: pattern select; 0 colour bars, 1 gradient, 2 solid, 3 checkerboard.
REQ-009 i_solid_rgb, input, 12: {R,G,B} 4 bits each, used by pattern 2.
REQ-010 o_vsync, output, 1: OV7670-style frame sync, active-high.
REQ-011 o_href, output, 1: line-valid, high while pixel bytes are valid.
REQ-012 o_pix_byte, output, 8: RGB444 pixel byte stream.
REQ-013 o_busy, output, 1: high whenever state != IDLE.
REQ-014 o_frame_done, output, 1: one-cycle pulse on the last cycle of each frame.
REQ-015 o_frame_cnt, output, 8: frames completed, wraps 255->0.

Function
REQ-016 FSM states SHALL be IDLE, VSYNC, VBP, ACTIVE, VFP, each a whole number of lines, with a column counter 0..LINE_LEN-1 and a line counter per state.
REQ-017 In IDLE, i_enable sampled high SHALL move to VSYNC on that edge; column and line counters SHALL be 0 on the first VSYNC cycle.
REQ-018 Transitions: VSYNC->VBP after VS_LINES lines; VBP->ACTIVE after VBP_LINES; ACTIVE->VFP after V_ACTIVE; VFP->VSYNC if i_enable=1, else IDLE; all transitions occur on the last column of the last line.
REQ-019 All outputs SHALL be registered; o_vsync SHALL be 1 exactly for VSYNC-state cycles, one cycle after the state is entered (fixed 1-cycle output latency for all outputs).
REQ-020 In ACTIVE, o_href SHALL be 1 for columns 0..2*H_ACTIVE-1 and 0 for the H_BLANK remainder; o_href = 0 in all other states.
REQ-021 Pixel x = column>>1, y = active line index; byte 0 (even column) = {4'h0,R}, byte 1 (odd column) = {G,B}.
REQ-022 o_pix_byte SHALL be 8'h00 whenever o_href = 0.
REQ-023 Pattern 0: 8 bars of width H_ACTIVE/8 (last bar absorbs remainder), left to right FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-024 Pattern 1: R = x[3:0], G = y[3:0], B = o_frame_cnt[3:0].
REQ-025 Pattern 2: RGB = i_solid_rgb, captured at frame start.
REQ-026 Pattern 3: RGB = FFF if x[4]^y[4], else 000.
REQ-027 i_pattern and i_solid_rgb SHALL be captured on entry to VSYNC; changes mid-frame SHALL take effect only from the next frame.
REQ-028 i_enable deasserted mid-frame SHALL NOT truncate the frame; generation stops at the end of VFP.
REQ-029 o_frame_done SHALL pulse on the VFP final cycle (registered: visible one cycle later); o_frame_cnt SHALL increment in the same cycle as the pulse.
REQ-030 Re-assertion of i_enable during the final VFP cycle SHALL give back-to-back frames with no IDLE cycle.

Reset
REQ-031 While i_rstn = 0: state IDLE, all counters 0, o_vsync = o_href = o_busy = o_frame_done = 0, o_pix_byte = 8'h00, o_frame_cnt = 0, captured pattern = 0.
REQ-032 Reset asserted mid-frame SHALL clear all outputs immediately, without waiting for a clock; after release, generation resumes only through the IDLE->VSYNC path.

Verification (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VS/VBP/VFP=1; LINE_LEN=20, frame=140 cycles)
REQ-033 Reset, i_enable=1 held -> o_vsync high exactly 20 cycles, then 20 cycles low before the first href; 4 href pulses of 16 cycles, period 20; o_frame_done every 140 cycles; o_frame_cnt 0,1,2.
REQ-034 i_pattern=2, i_solid_rgb=12'hA5C -> each active line is byte pairs 0x0A,0x5C x8; bytes 0x00 outside href.
REQ-035 i_pattern=0 -> line bytes 0F,FF, 0F,F0, 00,FF, 00,F0, 0F,0F, 0F,00, 00,0F, 00,00; identical on all 4 lines.
REQ-036 i_pattern changed 0->3 mid-ACTIVE -> current frame stays bars; next frame checkerboard (all 000 for x,y<16).
REQ-037 i_enable dropped in line 2 of ACTIVE -> frame completes, o_frame_done pulses, o_busy falls, o_vsync stays 0 thereafter.
REQ-038 i_rstn pulsed low mid-href -> o_href, o_pix_byte, o_busy are 0 before the next clock edge; a fresh full frame follows release.
